// File: rtl/instr_pkg.sv
// Shared definitions for the instruction issue unit: instruction field layout,
// opcodes, issue FSM states and the register-read decode used for hazard checks.
package instr_pkg;

    typedef logic [7:0] word_t;

    localparam int MODE_BIT  = 7;
    localparam int OPCODE_HI = 6;
    localparam int OPCODE_LO = 4;
    localparam int DEST_HI   = 3;
    localparam int DEST_LO   = 2;
    localparam int SRC1_HI   = 1;
    localparam int SRC1_LO   = 0;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_INC = 3'b011;

    localparam word_t NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } issue_state_t;

    typedef struct packed {
        logic       mode;
        logic [2:0] opcode;
        logic [1:0] dest;
        logic [1:0] src1;
    } instr_t;

    typedef struct packed {
        logic       wr;
        logic [1:0] dest;
    } sb_entry_t;

    function automatic instr_t decode(word_t w);
        instr_t d;
        d.mode   = w[MODE_BIT];
        d.opcode = w[OPCODE_HI:OPCODE_LO];
        d.dest   = w[DEST_HI:DEST_LO];
        d.src1   = w[SRC1_HI:SRC1_LO];
        return d;
    endfunction

    // True when instruction w reads register r as one of its sources.
    function automatic logic reads_reg(word_t w, logic [1:0] r);
        instr_t d;
        d = decode(w);
        case (d.opcode)
            OP_NOP:  return 1'b0;
            OP_INC:  return d.dest == r;
            OP_ADD:  return (d.dest == r) || (d.src1 == r);
            default: return (d.dest == r) || (d.src1 == r);
        endcase
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Load and issue channels between the instruction issue unit and its neighbours
// (program loader on one side, pipeline fetch stage on the other).
interface instr_issue_if;
    import instr_pkg::*;

    logic  load_valid;
    word_t load_instr;
    logic  load_ready;
    logic  stall;
    word_t issue_instr;
    logic  issue_valid;

    modport master (
        output load_valid, load_instr, stall,
        input  load_ready, issue_instr, issue_valid
    );

    modport slave (
        input  load_valid, load_instr, stall,
        output load_ready, issue_instr, issue_valid
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Shift register of recently issued {wr, dest} pairs; flags a candidate word
// that would read a register still being written by an in-flight instruction.
module hazard_scoreboard
    import instr_pkg::*;
#(
    parameter int GAP = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  shift_en,
    input  logic  clear,
    input  word_t issued_word,
    input  word_t cand_word,
    output logic  hazard
);

    sb_entry_t sb [GAP];
    instr_t    issued_d;

    assign issued_d = decode(issued_word);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < GAP; i++) sb[i] <= '0;
        end else if (shift_en) begin
            // Bubbles carry opcode 000, so they enter with wr = 0.
            sb[0] <= '{wr: (issued_d.opcode != OP_NOP), dest: issued_d.dest};
            for (int i = 1; i < GAP; i++) sb[i] <= sb[i-1];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            if (sb[i].wr && reads_reg(cand_word, sb[i].dest)) hazard = 1'b1;
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue unit: buffers a loaded program and streams it into fetch,
// inserting NOP bubbles while a source register is still being written.
module instr_issue
    import instr_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int HAZARD_GAP = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_issue_if.slave               bus,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] prog_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(HAZARD_GAP + 1);

    issue_state_t  state, state_nx;
    logic [AW-1:0] pc, pc_nx;
    logic [CW-1:0] count_q, count_nx;
    logic [DW-1:0] drain_cnt, drain_nx;
    word_t         issue_q, issue_nx;
    logic          valid_q, valid_nx;
    word_t         prog_buf [DEPTH];
    word_t         cand;
    logic          load_ok, load_fire, last_word, hazard, sb_shift, sb_clear;

    assign load_ok   = (state == ST_IDLE) && (count_q < CW'(DEPTH));
    assign load_fire = bus.load_valid && load_ok;
    assign cand      = prog_buf[pc];
    assign last_word = (CW'(pc) + CW'(1)) == count_q;

    // NOTE: the program buffer has no reset; prog_count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (load_fire) prog_buf[count_q[AW-1:0]] <= bus.load_instr;
    end

    hazard_scoreboard #(.GAP(HAZARD_GAP)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (sb_shift),
        .clear      (sb_clear),
        .issued_word(issue_nx),
        .cand_word  (cand),
        .hazard     (hazard)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        count_nx = count_q;
        drain_nx = drain_cnt;
        issue_nx = issue_q;
        valid_nx = valid_q;
        sb_shift = 1'b0;
        sb_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                issue_nx = NOP_WORD;
                valid_nx = 1'b0;
                if (load_fire) count_nx = count_q + CW'(1);
                if (start) begin
                    sb_clear = 1'b1;
                    pc_nx    = '0;
                    state_nx = (count_nx == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    sb_shift = 1'b1;
                    if (hazard) begin
                        issue_nx = NOP_WORD;
                        valid_nx = 1'b0;
                    end else begin
                        issue_nx = cand;
                        valid_nx = 1'b1;
                        if (last_word) begin
                            state_nx = ST_DRAIN;
                            drain_nx = '0;
                        end else begin
                            pc_nx = pc + AW'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!bus.stall) begin
                    sb_shift = 1'b1;
                    issue_nx = NOP_WORD;
                    valid_nx = 1'b0;
                    if (drain_cnt == DW'(HAZARD_GAP - 1)) state_nx = ST_DONE;
                    else                                   drain_nx = drain_cnt + DW'(1);
                end
            end
            ST_DONE: begin
                issue_nx = NOP_WORD;
                valid_nx = 1'b0;
                if (start && (count_q != '0)) begin
                    sb_clear = 1'b1;
                    pc_nx    = '0;
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= '0;
            count_q   <= '0;
            drain_cnt <= '0;
            issue_q   <= NOP_WORD;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            count_q   <= count_nx;
            drain_cnt <= drain_nx;
            issue_q   <= issue_nx;
            valid_q   <= valid_nx;
        end
    end

    assign bus.load_ready  = load_ok;
    assign bus.issue_instr = issue_q;
    assign bus.issue_valid = valid_q;
    assign busy            = (state == ST_RUN) || (state == ST_DRAIN);
    assign done            = (state == ST_DONE);
    assign prog_count      = count_q;

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: streaming, hazard bubbles, stall, full buffer,
// empty program, load+start in one cycle, restart from DONE and reset mid-run.
module tb_instr_issue;
    import instr_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] prog_count;
    int         n_cmp = 0;
    int         n_err = 0;

    instr_issue_if bus();

    instr_issue #(.DEPTH(16), .HAZARD_GAP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .prog_count(prog_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_issue(input string tag, input word_t w, input logic v);
        check({tag, ".instr"}, 32'(bus.issue_instr), 32'(w));
        check({tag, ".valid"}, 32'(bus.issue_valid), 32'(v));
    endtask

    task automatic load_word(input word_t w);
        bus.load_valid = 1'b1;
        bus.load_instr = w;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen_valid;
        reset          = 1'b1;
        start          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_instr = '0;
        bus.stall      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        expect_issue("rst", 8'h00, 1'b0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.load_ready", 32'(bus.load_ready), 32'd1);
        check("rst.prog_count", 32'(prog_count), 32'd0);

        // Independent pair ADD R0,R1 then INC R1: back-to-back, then 4 drain cycles
        load_word(8'h11);
        load_word(8'h35);
        check("indep.prog_count", 32'(prog_count), 32'd2);
        pulse_start();
        check("indep.busy", 32'(busy), 32'd1);
        tick(); expect_issue("indep.w0", 8'h11, 1'b1);
        tick(); expect_issue("indep.w1", 8'h35, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_issue("indep.drain", 8'h00, 1'b0);
            check("indep.drain_done", 32'(done), 32'd0);
        end
        tick();
        check("indep.done", 32'(done), 32'd1);
        check("indep.done_busy", 32'(busy), 32'd0);
        check("indep.done_load_ready", 32'(bus.load_ready), 32'd0);
        expect_issue("indep.done_out", 8'h00, 1'b0);

        // Loads are refused in DONE; start replays the retained program
        load_word(8'h3C);
        check("done.no_load", 32'(prog_count), 32'd2);
        pulse_start();
        check("restart.done", 32'(done), 32'd0);
        tick(); expect_issue("restart.w0", 8'h11, 1'b1);
        tick(); expect_issue("restart.w1", 8'h35, 1'b1);
        repeat (4) tick();
        check("restart.done_again", 32'(done), 32'd1);

        // Dependent pair INC R1 then ADD R0,R1: exactly 4 bubbles
        do_reset();
        load_word(8'h34);
        load_word(8'h11);
        pulse_start();
        tick(); expect_issue("dep.w0", 8'h34, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_issue("dep.bubble", 8'h00, 1'b0);
        end
        tick(); expect_issue("dep.w1", 8'h11, 1'b1);

        // Stall right after the writer issues: outputs hold, then still 4 bubbles
        do_reset();
        load_word(8'h34);
        load_word(8'h11);
        pulse_start();
        tick(); expect_issue("stall.w0", 8'h34, 1'b1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_issue("stall.hold", 8'h34, 1'b1);
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_issue("stall.bubble", 8'h00, 1'b0);
        end
        tick(); expect_issue("stall.w1", 8'h11, 1'b1);

        // Full buffer: 17th word refused (stall held to show it does not block loading)
        do_reset();
        bus.stall      = 1'b1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.load_instr = 8'(i + 1);
            if (i == 15) check("full.ready_at_15", 32'(bus.load_ready), 32'd1);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.stall      = 1'b0;
        check("full.prog_count", 32'(prog_count), 32'd16);
        check("full.load_ready", 32'(bus.load_ready), 32'd0);

        // Empty program: start goes straight to DONE, no valid issue ever
        do_reset();
        pulse_start();
        check("empty.done", 32'(done), 32'd1);
        check("empty.busy", 32'(busy), 32'd0);
        seen_valid = bus.issue_valid;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_valid = seen_valid | bus.issue_valid;
            tick();
        end
        check("empty.never_valid", 32'(seen_valid), 32'd0);
        check("empty.still_done", 32'(done), 32'd1);

        // Load and start in the same cycle: the word joins the program
        do_reset();
        bus.load_valid = 1'b1;
        bus.load_instr = 8'h3C;
        start          = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        start          = 1'b0;
        check("ldstart.prog_count", 32'(prog_count), 32'd1);
        check("ldstart.busy", 32'(busy), 32'd1);
        tick(); expect_issue("ldstart.w0", 8'h3C, 1'b1);

        // Reset in RUN at pc = 2
        do_reset();
        load_word(8'h11);
        load_word(8'h35);
        load_word(8'h38);
        load_word(8'h3C);
        pulse_start();
        tick(); expect_issue("midrst.w0", 8'h11, 1'b1);
        tick(); expect_issue("midrst.w1", 8'h35, 1'b1);
        check("midrst.pre_busy", 32'(busy), 32'd1);
        do_reset();
        expect_issue("midrst.out", 8'h00, 1'b0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.prog_count", 32'(prog_count), 32'd0);
        check("midrst.load_ready", 32'(bus.load_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
